control_juego: RTL and testbench

//  Sequencer for the 4x4 2048 board datapath. Turns debounced direction buttons into the
//  4-bit estado / 3-bit mov code sequence the board logic consumes: compress, latch, merge,

---
 rtl/control_juego_if.sv | 22 ++
 rtl/control_juego.sv | 99 +++++++++
 tb/tb_control_juego.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_juego_if.sv
// control_juego_if: buttons/board in, phase codes and spawn requests out; slave faces the sequencer
interface control_juego_if;
  logic [3:0] btn;
  logic [3:0][3:0][11:0] matriz;
  logic [3:0] estado;
  logic [2:0] mov;
  logic spawn_en;
  logic [1:0] spawn_fila;
  logic [1:0] spawn_col;
  logic [11:0] spawn_valor;
  logic ocupado;
  logic gano;
  logic perdio;
  modport slave (
    input  btn, matriz,
    output estado, mov, spawn_en, spawn_fila, spawn_col, spawn_valor, ocupado, gano, perdio
  );
  modport master (
    output btn, matriz,
    input  estado, mov, spawn_en, spawn_fila, spawn_col, spawn_valor, ocupado, gano, perdio
  );
endinterface

// File: rtl/control_juego.sv
// control_juego: 2048 move sequencer with LFSR tile spawning and win/loss detection; MOV_NULO_CHECK_EN skips spawning after no-op moves
module control_juego #(
  parameter logic [15:0] LFSR_SEMILLA = 16'hACE1,
  parameter logic [11:0] VALOR_META = 12'd2048,
  parameter logic [3:0] PROB4_MASK = 4'hF
) (
  input logic clk,
  input logic rst_n,
  control_juego_if.slave bus
);
  // low nibble is the estado code, upper bits separate states sharing a code
  typedef enum logic [5:0] {
    ESPERA = 6'h00, INI_GEN1 = 6'h01, INI_GEN2 = 6'h11, GENERAR = 6'h21,
    VER_GANO = 6'h03, VER_PERDIO = 6'h13, COMPRIMIR = 6'h04, LATCH1 = 6'h05,
    COMBINAR = 6'h06, LATCH2 = 6'h07, GANO = 6'h08, LIMPIAR = 6'h09,
    PERDIO = 6'h0A, INI_LIMPIAR = 6'h0B
  } estado_e;
  estado_e state_q, state_d;
  logic [15:0] lfsr_q;
  logic [3:0] btn_q, idx_q, idx_d, cnt_q, cnt_d;
  logic [2:0] mov_q, mov_d, mov_btn;
  logic [15:0] es_meta, es_vacia;
  logic [23:0] es_par;
  logic acepta, es_gen, entra_gen, spawn, fin_gen, sin_efecto;
  for (genvar f = 0; f < 4; f++) begin : g_f
    for (genvar c = 0; c < 4; c++) begin : g_c
      assign es_meta[4*f+c] = bus.matriz[f][c] == VALOR_META;
      assign es_vacia[4*f+c] = bus.matriz[f][c] == 12'd0;
    end
    for (genvar c = 0; c < 3; c++) begin : g_p
      assign es_par[6*f+c] = bus.matriz[f][c] == bus.matriz[f][c+1];
      assign es_par[6*f+3+c] = bus.matriz[c][f] == bus.matriz[c+1][f];
    end
  end
`ifdef MOV_NULO_CHECK_EN
  logic [3:0][3:0][11:0] snap_q;
  always_ff @(posedge clk)
    if (rst_n && acepta) snap_q <= bus.matriz;
  assign sin_efecto = bus.matriz == snap_q;
`else
  assign sin_efecto = 1'b0;
`endif
  assign acepta = state_q == ESPERA && bus.btn != 4'd0 && (bus.btn & (bus.btn - 4'd1)) == 4'd0
                  && (bus.btn & ~btn_q) != 4'd0;
  assign mov_btn = bus.btn[3] ? 3'b011 : bus.btn[2] ? 3'b100 : bus.btn[1] ? 3'b010 : 3'b001;
  assign es_gen = state_q inside {INI_GEN1, INI_GEN2, GENERAR};
  assign spawn = es_gen && es_vacia[idx_q];
  // a full board exhausts 16 probes and leaves without spawning
  assign fin_gen = spawn || (es_gen && cnt_q == 4'd15);
  always_comb begin
    state_d = state_q;
    case (state_q)
      INI_LIMPIAR: state_d = INI_GEN1;
      INI_GEN1:    state_d = fin_gen ? INI_GEN2 : INI_GEN1;
      INI_GEN2:    state_d = fin_gen ? ESPERA : INI_GEN2;
      ESPERA:      state_d = acepta ? COMPRIMIR : ESPERA;
      COMPRIMIR:   state_d = LATCH1;
      LATCH1:      state_d = COMBINAR;
      COMBINAR:    state_d = LATCH2;
      LATCH2:      state_d = LIMPIAR;
      LIMPIAR:     state_d = VER_GANO;
      VER_GANO:    state_d = (|es_meta) ? GANO : sin_efecto ? ESPERA : GENERAR;
      GENERAR:     state_d = fin_gen ? VER_PERDIO : GENERAR;
      VER_PERDIO:  state_d = (!(|es_vacia) && !(|es_par)) ? PERDIO : ESPERA;
      default:     state_d = state_q;
    endcase
  end
  always_comb begin
    entra_gen = state_d != state_q && state_d inside {INI_GEN1, INI_GEN2, GENERAR};
    idx_d = entra_gen ? lfsr_q[3:0] : es_gen ? idx_q + 4'd1 : idx_q;
    cnt_d = entra_gen ? 4'd0 : es_gen ? cnt_q + 4'd1 : cnt_q;
    mov_d = state_d == ESPERA ? 3'b000 : acepta ? mov_btn : mov_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= INI_LIMPIAR;
      lfsr_q <= LFSR_SEMILLA;
      btn_q <= 4'd0;
      idx_q <= 4'd0;
      cnt_q <= 4'd0;
      mov_q <= 3'b000;
    end else begin
      state_q <= state_d;
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      btn_q <= bus.btn;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      mov_q <= mov_d;
    end
  assign bus.estado = state_q[3:0];
  assign bus.mov = mov_q;
  assign bus.spawn_en = spawn;
  assign bus.spawn_fila = spawn ? idx_q[3:2] : 2'd0;
  assign bus.spawn_col = spawn ? idx_q[1:0] : 2'd0;
  assign bus.spawn_valor = !spawn ? 12'd0 : (lfsr_q[7:4] & PROB4_MASK) == 4'd0 ? 12'd4 : 12'd2;
  assign bus.ocupado = !(state_q inside {ESPERA, GANO, PERDIO});
  assign bus.gano = state_q == GANO;
  assign bus.perdio = state_q == PERDIO;
endmodule

// File: tb/tb_control_juego.sv
// tb_control_juego: directed bench; models the board register and LFSR, scoreboards phase codes per move
module tb_control_juego;
  typedef logic [3:0][3:0][11:0] tablero_t;
  typedef struct packed {logic [3:0] estado; logic [2:0] mov;} esp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic carga = 1'b0;
  logic post_ok = 1'b0;
  logic [3:0] btn = 4'd0;
  tablero_t tablero, carga_val, post_val, b;
  logic [15:0] lf_m;
  logic [15:0] lf_hist[18];
  esp_t exp_q[$];
  esp_t e_m;
  int checks = 0;
  int errors = 0;
  int n_spawn = 0;
  int n_mov = 0;
  int ns0, nm0;
  always #5 clk = ~clk;
  control_juego_if bus();
  assign bus.btn = btn;
  assign bus.matriz = tablero;
  control_juego dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(posedge clk)
    if (carga) tablero <= carga_val;
    else if (bus.spawn_en) tablero[bus.spawn_fila][bus.spawn_col] <= bus.spawn_valor;
    else if (post_ok && bus.estado == 4'b0111) tablero <= post_val;
  always @(posedge clk)
    lf_m <= !rst_n ? 16'hACE1 : {lf_m[14:0], lf_m[15] ^ lf_m[13] ^ lf_m[12] ^ lf_m[10]};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  // spawn at idx is legal if some probe count p from the entry LFSR value lands there past full cells
  function automatic logic pos_ok(input logic [3:0] idx);
    logic [3:0] s, j;
    logic lleno;
    pos_ok = 1'b0;
    for (int p = 0; p < 16; p++) begin
      s = lf_hist[p][3:0];
      lleno = 1'b1;
      for (int k = 0; k < p; k++) begin
        j = s + k[3:0];
        lleno &= tablero[j[3:2]][j[1:0]] != 12'd0;
      end
      if (lleno && s + p[3:0] == idx) pos_ok = 1'b1;
    end
  endfunction
  function automatic int n_fichas(input tablero_t t);
    n_fichas = 0;
    for (int i = 0; i < 16; i++)
      if (t[i/4][i%4] == 12'd2 || t[i/4][i%4] == 12'd4) n_fichas++;
  endfunction
  function automatic tablero_t cheq(input int k);
    for (int i = 0; i < 16; i++) cheq[i/4][i%4] = ((i/4 + i%4 + k) % 2 != 0) ? 12'd4 : 12'd2;
  endfunction
  always @(negedge clk) begin
    lf_hist[0] <= lf_m;
    for (int i = 1; i < 18; i++) lf_hist[i] <= lf_hist[i-1];
    if (rst_n && bus.estado == 4'b0100) n_mov <= n_mov + 1;
    if (exp_q.size() != 0) begin
      e_m = exp_q.pop_front();
      chk("estado_seq", bus.estado, e_m.estado);
      chk("mov_seq", bus.mov, e_m.mov);
    end
    if (rst_n && bus.spawn_en) begin
      n_spawn <= n_spawn + 1;
      chk("spawn_celda_vacia", tablero[bus.spawn_fila][bus.spawn_col], 0);
      chk("spawn_valor", bus.spawn_valor, (lf_m[7:4] == 4'd0) ? 4 : 2);
      chk("spawn_pos", pos_ok({bus.spawn_fila, bus.spawn_col}), 1);
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic reset_dut(input tablero_t t);
    rst_n = 1'b0;
    btn = 4'd0;
    post_ok = 1'b0;
    carga = 1'b1;
    carga_val = t;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    carga = 1'b0;
  endtask
  task automatic load(input tablero_t t);
    carga = 1'b1;
    carga_val = t;
    step(1);
    carga = 1'b0;
  endtask
  task automatic push6(input logic [2:0] m);
    exp_q.push_back({4'b0100, m});
    exp_q.push_back({4'b0101, m});
    exp_q.push_back({4'b0110, m});
    exp_q.push_back({4'b0111, m});
    exp_q.push_back({4'b1001, m});
    exp_q.push_back({4'b0011, m});
  endtask
  task automatic drain(input int lim, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      step(1);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic wait_est(input logic [3:0] code, input int lim, input string tag);
    int n;
    n = 0;
    while (bus.estado !== code && n < lim) begin
      step(1);
      n++;
    end
    chk(tag, bus.estado, code);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    reset_dut('0);
    chk("rst_estado", bus.estado, 4'b1011);
    chk("rst_mov", bus.mov, 3'b000);
    chk("rst_gano", bus.gano, 1'b0);
    chk("rst_perdio", bus.perdio, 1'b0);
    chk("rst_ocupado", bus.ocupado, 1'b1);
    chk("rst_spawn_en", bus.spawn_en, 1'b0);
    ns0 = n_spawn;
    rst_n = 1'b1;
    wait_est(4'b0000, 40, "ini_espera");
    chk("ini_spawns", n_spawn - ns0, 2);
    chk("ini_fichas", n_fichas(tablero), 2);
    chk("ini_ocupado", bus.ocupado, 1'b0);
    b = '0;
    b[0][0] = 12'd2;
    b[0][1] = 12'd2;
    load(b);
    post_val = '0;
    post_val[0][0] = 12'd4;
    post_ok = 1'b1;
    ns0 = n_spawn;
    nm0 = n_mov;
    btn = 4'b0001;
    push6(3'b001);
    drain(12, "t2_fases");
    wait_est(4'b0000, 30, "t2_espera");
    chk("t2_spawns", n_spawn - ns0, 1);
    chk("t2_ocupado", bus.ocupado, 1'b0);
    chk("t2_mov_nulo", bus.mov, 3'b000);
    chk("t2_movs", n_mov - nm0, 1);
    btn = 4'd0;
    step(2);
    b = '0;
    b[1][2] = 12'd8;
    load(b);
    post_val = '0;
    post_val[1][0] = 12'd8;
    ns0 = n_spawn;
    nm0 = n_mov;
    btn = 4'b0001;
    push6(3'b001);
    step(10);
    btn = 4'b0011;
    drain(12, "t3_fases");
    wait_est(4'b0000, 30, "t3_espera");
    step(6);
    chk("t3_sigue_espera", bus.estado, 4'b0000);
    chk("t3_un_mov", n_mov - nm0, 1);
    chk("t3_spawns", n_spawn - ns0, 1);
    btn = 4'd0;
    step(2);
    b = '0;
    b[2][0] = 12'd1024;
    b[2][1] = 12'd1024;
    load(b);
    post_val = '0;
    post_val[2][0] = 12'd2048;
    ns0 = n_spawn;
    nm0 = n_mov;
    btn = 4'b0001;
    push6(3'b001);
    drain(12, "t4_fases");
    step(1);
    chk("t4_gano_estado", bus.estado, 4'b1000);
    chk("t4_gano", bus.gano, 1'b1);
    chk("t4_perdio", bus.perdio, 1'b0);
    chk("t4_ocupado", bus.ocupado, 1'b0);
    btn = 4'd0;
    step(2);
    btn = 4'b1000;
    step(5);
    chk("t4_terminal", bus.estado, 4'b1000);
    chk("t4_ignora", n_mov - nm0, 1);
    chk("t4_sin_spawn", n_spawn - ns0, 0);
    reset_dut('0);
    rst_n = 1'b1;
    wait_est(4'b0000, 40, "t5_ini");
    for (int v = 0; v < 3; v++) begin
      btn = 4'd0;
      step(2);
      load(cheq(0));
      post_val = cheq(1);
      if (v == 0) post_val[3][3] = post_val[3][2];
      if (v == 1) post_val[3][3] = post_val[2][3];
      post_ok = 1'b1;
      ns0 = n_spawn;
      btn = 4'b1000;
      push6(3'b011);
      drain(12, "t5_fases");
      wait_est(v < 2 ? 4'b0000 : 4'b1010, 40, "t5_final");
      chk("t5_perdio", bus.perdio, v == 2);
      chk("t5_sin_spawn", n_spawn - ns0, 0);
    end
    chk("t5_gano", bus.gano, 1'b0);
    chk("t5_ocupado", bus.ocupado, 1'b0);
    reset_dut('0);
    rst_n = 1'b1;
    wait_est(4'b0000, 40, "t6_ini");
    b = '0;
    for (int f = 0; f < 4; f++) b[f][0] = (f % 2 != 0) ? 12'd4 : 12'd2;
    load(b);
    post_ok = 1'b0;
    ns0 = n_spawn;
    btn = 4'b0001;
    push6(3'b001);
`ifdef MOV_NULO_CHECK_EN
    exp_q.push_back({4'b0000, 3'b000});
    drain(12, "t6_fases");
    chk("t6_nulo_spawns", n_spawn - ns0, 0);
    chk("t6_ocupado", bus.ocupado, 1'b0);
`else
    drain(12, "t6_fases");
    wait_est(4'b0000, 30, "t6_espera");
    chk("t6_spawns", n_spawn - ns0, 1);
`endif
    btn = 4'd0;
    step(2);
    btn = 4'b0010;
    exp_q.push_back({4'b0100, 3'b010});
    exp_q.push_back({4'b0101, 3'b010});
    exp_q.push_back({4'b0110, 3'b010});
    drain(6, "t6_hasta_combinar");
    rst_n = 1'b0;
    step(1);
    chk("t6_rst_estado", bus.estado, 4'b1011);
    chk("t6_rst_mov", bus.mov, 3'b000);
    chk("t6_rst_ocupado", bus.ocupado, 1'b1);
    rst_n = 1'b1;
    btn = 4'd0;
    wait_est(4'b0000, 40, "t6_reinicio");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
